// File: rtl/sirv_uartrx_ctrl_if.sv
// ---------------------------------------------------------------------------
// sirv_uartrx_ctrl_if
// Pop port of the UART RX byte FIFO (valid/ready handshake).
//   deq_valid  FIFO holds at least one byte (driven by the controller)
//   deq_bits   byte at the FIFO head          (driven by the controller)
//   deq_ready  pop request                     (driven by the consumer)
// A byte is popped on any clock edge where deq_valid & deq_ready.
// ---------------------------------------------------------------------------
interface sirv_uartrx_ctrl_if;
    logic       deq_valid;
    logic [7:0] deq_bits;
    logic       deq_ready;

    modport master (
        output deq_valid,
        output deq_bits,
        input  deq_ready
    );

    modport slave (
        input  deq_valid,
        input  deq_bits,
        output deq_ready
    );
endinterface

// File: rtl/sirv_uartrx_ctrl.sv
// ---------------------------------------------------------------------------
// sirv_uartrx_ctrl
// Receive-side controller between the UART RX datapath and the register file.
//  - Sequences the datapath enable (rx_en) and divisor (rx_div). A divisor
//    write while running disables the datapath for HOLD_CYC cycles, loads the
//    new divisor one cycle before re-enabling, then returns to RUN (or OFF if
//    the receiver was disabled meanwhile).
//  - Buffers received bytes in a DEPTH-entry FIFO drained through deq.
//  - Raises the watermark interrupt and a sticky overflow flag.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_en               receiver enable
//   cfg_div_wr/_wdata    divisor write pulse and value
//   cfg_rxcnt            watermark threshold (ip_rxwm = count > cfg_rxcnt)
//   fifo_flush           pulse: empty the FIFO
//   rx_valid/rx_bits     byte-complete strobe and byte from the datapath
//   rx_en/rx_div         registered controls to the datapath
//   deq                  FIFO pop port (master side)
//   fifo_count           occupancy 0..DEPTH
//   ip_rxwm              watermark interrupt pending
//   ovf_flag/ovf_clr     sticky overflow flag and its clear
// ---------------------------------------------------------------------------
module sirv_uartrx_ctrl #(
    parameter int          DEPTH    = 8,
    parameter int          AW       = 3,
    parameter int          HOLD_CYC = 4,
    parameter logic [15:0] RST_DIV  = 16'h021E
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic                 cfg_div_wr,
    input  logic [15:0]          cfg_div_wdata,
    input  logic [AW-1:0]        cfg_rxcnt,
    input  logic                 fifo_flush,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_bits,
    output logic                 rx_en,
    output logic [15:0]          rx_div,
    sirv_uartrx_ctrl_if.master   deq,
    output logic [AW:0]          fifo_count,
    output logic                 ip_rxwm,
    output logic                 ovf_flag,
    input  logic                 ovf_clr
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYC - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [15:0]     pend_div_reg;

    // -----------------------------------------------------------------------
    // Enable / divisor sequencing
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_OFF;
            rx_en        <= 1'b0;
            rx_div       <= RST_DIV;
            hold_cnt_reg <= '0;
            pend_div_reg <= '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    // Datapath already disabled: apply directly. Staying in
                    // OFF for this cycle keeps the divisor update strictly
                    // ahead of rx_en rising.
                    if (cfg_div_wr) begin
                        rx_div <= cfg_div_wdata;
                    end else if (cfg_en) begin
                        state_reg <= ST_RUN;
                        rx_en     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A divisor write wins over a same-cycle disable so the
                    // write is not lost; HOLD then exits to OFF.
                    if (cfg_div_wr) begin
                        state_reg    <= ST_HOLD;
                        rx_en        <= 1'b0;
                        pend_div_reg <= cfg_div_wdata;
                        hold_cnt_reg <= HOLD_RELOAD;
                    end else if (!cfg_en) begin
                        state_reg <= ST_OFF;
                        rx_en     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cfg_div_wr) begin
                        pend_div_reg <= cfg_div_wdata;
                        hold_cnt_reg <= HOLD_RELOAD;
                    end else if (hold_cnt_reg == '0) begin
                        // Reassigning here only matters when HOLD_CYC == 1,
                        // where the counter is already 0 on entry.
                        rx_div    <= pend_div_reg;
                        state_reg <= cfg_en ? ST_RUN : ST_OFF;
                        rx_en     <= cfg_en;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                        // Counter reaching 0: new divisor becomes visible one
                        // cycle before rx_en is released.
                        if (hold_cnt_reg == HW'(1)) begin
                            rx_div <= pend_div_reg;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_OFF;
                    rx_en     <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Byte FIFO
    // -----------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          ovf_reg;

    logic push_req, pop_req, full, do_push, do_pop, ovf_set;

    assign push_req = rx_valid & rx_en;
    assign pop_req  = deq.deq_valid & deq.deq_ready;
    assign full     = (count_reg == FULL_COUNT);
    // When full, a same-cycle pop frees the slot the push uses.
    assign do_push  = push_req & (~full | pop_req) & ~fifo_flush;
    assign do_pop   = pop_req & ~fifo_flush;
    assign ovf_set  = push_req & full & ~pop_req & ~fifo_flush;

    // Storage has no reset; only entries between the pointers are observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= rx_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (fifo_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (ovf_set) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign deq.deq_valid = (count_reg != '0);
    assign deq.deq_bits  = mem[rd_ptr_reg];
    assign fifo_count    = count_reg;
    assign ip_rxwm       = (count_reg > {1'b0, cfg_rxcnt});
    assign ovf_flag      = ovf_reg;

endmodule

// File: tb/tb_sirv_uartrx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sirv_uartrx_ctrl
// Directed steps plus a randomized FIFO phase. The FIFO is modelled as a
// byte queue; enable/divisor timing is checked against cycle tables.
// ---------------------------------------------------------------------------
module tb_sirv_uartrx_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_en;
    logic          cfg_div_wr;
    logic [15:0]   cfg_div_wdata;
    logic [AW-1:0] cfg_rxcnt;
    logic          fifo_flush;
    logic          rx_valid;
    logic [7:0]    rx_bits;
    logic          rx_en;
    logic [15:0]   rx_div;
    logic [AW:0]   fifo_count;
    logic          ip_rxwm;
    logic          ovf_flag;
    logic          ovf_clr;

    sirv_uartrx_ctrl_if deq_if ();

    sirv_uartrx_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .HOLD_CYC (4),
        .RST_DIV  (16'h021E)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_div_wr    (cfg_div_wr),
        .cfg_div_wdata (cfg_div_wdata),
        .cfg_rxcnt     (cfg_rxcnt),
        .fifo_flush    (fifo_flush),
        .rx_valid      (rx_valid),
        .rx_bits       (rx_bits),
        .rx_en         (rx_en),
        .rx_div        (rx_div),
        .deq           (deq_if),
        .fifo_count    (fifo_count),
        .ip_rxwm       (ip_rxwm),
        .ovf_flag      (ovf_flag),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, overflow flag, and the rx_en level the
    // datapath currently sees (decides whether rx_valid is accepted).
    byte unsigned q[$];
    bit           m_ovf;
    bit           m_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the current inputs, then let the
    // DUT take the same edge and settle.
    task automatic tick();
        int  n;
        bit  push;
        bit  pop;
        n    = q.size();
        push = rx_valid && m_en;
        pop  = deq_if.deq_ready && (n != 0);
        if (fifo_flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (n < DEPTH || pop) q.push_back(rx_bits);
                else m_ovf = 1'b1;
            end
        end
        if (!(push && n == DEPTH && !pop && !fifo_flush) && ovf_clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, ".count"}, fifo_count, q.size());
        chk({tag, ".valid"}, deq_if.deq_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, ".head"}, deq_if.deq_bits, q[0]);
        chk({tag, ".wm"},  ip_rxwm,  q.size() > int'(cfg_rxcnt));
        chk({tag, ".ovf"}, ovf_flag, m_ovf);
        $display("[%0t] %s count=%0d head=%02h wm=%0b ovf=%0b", $time, tag,
                 fifo_count, deq_if.deq_bits, ip_rxwm, ovf_flag);
    endtask

    // Double divisor write: 0x0100, then 0x0200 two cycles into HOLD.
    bit          t5_wr  [7] = '{1, 0, 1, 0, 0, 0, 0};
    logic [15:0] t5_wd  [7] = '{16'h0100, 16'h0, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0};
    bit          t5_en  [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [15:0] t5_div [7] = '{16'h021E, 16'h021E, 16'h021E, 16'h021E, 16'h021E, 16'h0200, 16'h0200};
    // Single divisor write 0x0100 from 0x0200.
    bit          t4_en  [5] = '{0, 0, 0, 0, 1};
    logic [15:0] t4_div [5] = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0100};

    initial begin
        rst_n         = 1'b0;
        cfg_en        = 1'b0;
        cfg_div_wr    = 1'b0;
        cfg_div_wdata = 16'h0;
        cfg_rxcnt     = 3'd7;
        fifo_flush    = 1'b0;
        rx_valid      = 1'b0;
        rx_bits       = 8'h0;
        ovf_clr       = 1'b0;
        deq_if.deq_ready = 1'b0;
        m_ovf = 1'b0;
        m_en  = 1'b0;

        // ---- reset values ----
        repeat (2) begin @(posedge clk); #1; end
        chk("rst.rx_en",  rx_en,  0);
        chk("rst.rx_div", rx_div, 16'h021E);
        check_fifo("rst");
        rst_n = 1'b1;

        // ---- enable: rx_en one cycle later ----
        cfg_en = 1'b1;
        tick();
        chk("en.rx_en", rx_en, 1);
        m_en = 1'b1;
        $display("[%0t] enable rx_en=%0b", $time, rx_en);

        // ---- two bytes in, two bytes out ----
        rx_valid = 1'b1; rx_bits = 8'h55; tick();
        rx_bits = 8'hA3; tick();
        rx_valid = 1'b0;
        chk("two.count", fifo_count, 2);
        chk("two.head",  deq_if.deq_bits, 8'h55);
        check_fifo("two.push");
        deq_if.deq_ready = 1'b1;
        tick();
        chk("two.pop1", deq_if.deq_bits, 8'hA3);
        check_fifo("two.pop1");
        tick();
        chk("two.empty", deq_if.deq_valid, 0);
        check_fifo("two.pop2");
        deq_if.deq_ready = 1'b0;

        // ---- overflow: 9 pushes into 8 entries ----
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_bits = 8'(i + 1);
            tick();
            check_fifo($sformatf("fill%0d", i));
        end
        chk("ovf.count", fifo_count, 8);
        chk("ovf.flag",  ovf_flag,   1);
        // clear and overflowing push together: set wins
        ovf_clr = 1'b1; rx_bits = 8'hEE; tick();
        ovf_clr = 1'b0; rx_valid = 1'b0;
        chk("ovf.setwins", ovf_flag, 1);
        check_fifo("ovf.setwins");
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf.clr", ovf_flag, 0);

        // ---- full with simultaneous push and pop ----
        rx_valid = 1'b1; rx_bits = 8'h11; deq_if.deq_ready = 1'b1;
        tick();
        rx_valid = 1'b0; deq_if.deq_ready = 1'b0;
        chk("fullpp.count", fifo_count, 8);
        chk("fullpp.ovf",   ovf_flag,   0);
        chk("fullpp.head",  deq_if.deq_bits, 8'h02);
        deq_if.deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_fifo($sformatf("drain%0d", i));
            if (i == 7) chk("fullpp.last", deq_if.deq_bits, 8'h11);
            tick();
        end
        deq_if.deq_ready = 1'b0;
        check_fifo("drained");

        // ---- randomized FIFO traffic ----
        for (int i = 0; i < 300; i++) begin
            rx_valid         = ($urandom_range(1) == 1);
            rx_bits          = 8'($urandom);
            deq_if.deq_ready = ($urandom_range(2) == 0);
            fifo_flush       = ($urandom_range(39) == 0);
            ovf_clr          = ($urandom_range(19) == 0);
            cfg_rxcnt        = 3'($urandom);
            tick();
            check_fifo($sformatf("rnd%0d", i));
        end
        rx_valid = 1'b0; deq_if.deq_ready = 1'b0; ovf_clr = 1'b0;
        cfg_rxcnt = 3'd7;
        fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check_fifo("rnd.end");

        // ---- divisor write restarted during HOLD ----
        for (int i = 0; i < 7; i++) begin
            cfg_div_wr    = t5_wr[i];
            cfg_div_wdata = t5_wd[i];
            tick();
            cfg_div_wr = 1'b0;
            chk($sformatf("hold2.en%0d", i),  rx_en,  t5_en[i]);
            chk($sformatf("hold2.div%0d", i), rx_div, t5_div[i]);
            m_en = t5_en[i];
            $display("[%0t] hold2 step%0d rx_en=%0b rx_div=%04h", $time, i, rx_en, rx_div);
        end

        // ---- single divisor write, rx_valid ignored while held ----
        for (int i = 0; i < 5; i++) begin
            cfg_div_wr    = (i == 0);
            cfg_div_wdata = 16'h0100;
            rx_valid      = (i >= 1);
            rx_bits       = 8'h77;
            tick();
            cfg_div_wr = 1'b0;
            chk($sformatf("hold1.en%0d", i),  rx_en,  t4_en[i]);
            chk($sformatf("hold1.div%0d", i), rx_div, t4_div[i]);
            m_en = t4_en[i];
            $display("[%0t] hold1 step%0d rx_en=%0b rx_div=%04h", $time, i, rx_en, rx_div);
        end
        rx_valid = 1'b0;
        chk("hold1.nopush", fifo_count, 0);
        check_fifo("hold1");

        // ---- watermark and flush ----
        cfg_rxcnt = 3'd2;
        rx_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rx_bits = 8'(i);
            tick();
            chk($sformatf("wm.at%0d", i), ip_rxwm, (i == 3));
            check_fifo($sformatf("wm%0d", i));
        end
        rx_valid = 1'b0;
        fifo_flush = 1'b1; tick(); fifo_flush = 1'b0;
        chk("flush.count", fifo_count, 0);
        chk("flush.wm",    ip_rxwm,    0);
        check_fifo("flush");

        // ---- async reset in the middle of HOLD ----
        cfg_div_wr = 1'b1; cfg_div_wdata = 16'h0400; tick(); cfg_div_wr = 1'b0;
        m_en = 1'b0;
        tick();
        chk("arst.pre_en", rx_en, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.div", rx_div, 16'h021E);
        chk("arst.en",  rx_en,  0);
        $display("[%0t] async reset rx_en=%0b rx_div=%04h", $time, rx_en, rx_div);
        q.delete(); m_ovf = 1'b0;
        @(posedge clk); #1;
        chk("arst.held_en", rx_en, 0);
        check_fifo("arst");
        rst_n = 1'b1;
        tick();
        chk("arst.run_en",  rx_en,  1);
        chk("arst.run_div", rx_div, 16'h021E);
        $display("[%0t] after reset rx_en=%0b rx_div=%04h", $time, rx_en, rx_div);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sirv_uartrx_ctrl.md
Name: sirv_uartrx_ctrl

Overview:
- Receive-side controller for the UART RX datapath; sits between the datapath and the UART register file.
- Owns and sequences the datapath controls: enable and divisor. A divisor change goes through a hold window with the datapath disabled, then the new value is applied.
- Buffers received bytes in a DEPTH-entry FIFO that software drains through a valid/ready pop port.
- Generates the RX watermark interrupt and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 3, log2(DEPTH).
- HOLD_CYC, 4, cycles rx_en is held low around a divisor change; at least 1.
- RST_DIV, 16'h021E, divisor value after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_en  in  1  receiver enable from register file
- cfg_div_wr  in  1  one-cycle pulse: new divisor written
- cfg_div_wdata  in  16  new divisor value
- cfg_rxcnt  in  AW  watermark threshold
- fifo_flush  in  1  one-cycle pulse: empty the FIFO
- rx_valid  in  1  byte-complete strobe from RX datapath
- rx_bits  in  8  received byte
- rx_en  out  1  enable to RX datapath
- rx_div  out  16  divisor to RX datapath
- deq_valid  out  1  FIFO not empty
- deq_bits  out  8  FIFO head byte
- deq_ready  in  1  pop request
- fifo_count  out  AW+1  current occupancy, 0..DEPTH
- ip_rxwm  out  1  watermark interrupt pending
- ovf_flag  out  1  sticky overflow
- ovf_clr  in  1  clears ovf_flag

Behaviour:
- Reset values (rst_n low, async): state OFF, rx_en 0, rx_div RST_DIV, FIFO empty, fifo_count 0, deq_valid 0, ip_rxwm 0, ovf_flag 0, hold counter 0, pending divisor cleared.
- FSM states: OFF, RUN, HOLD, all registered.
  - OFF: rx_en=0. Goes to RUN when cfg_en=1 and no divisor change is pending.
  - RUN: rx_en=1. Goes to OFF when cfg_en=0. Goes to HOLD on cfg_div_wr.
  - HOLD: rx_en=0. Counter loads HOLD_CYC-1 on entry and decrements each cycle.
  - Leaving HOLD: when the counter reaches 0, rx_div <= pending divisor. Next state is RUN if cfg_en=1, otherwise OFF.
- cfg_div_wr in OFF: rx_div updates on the next edge; no HOLD.
- cfg_div_wr during HOLD: pending divisor is overwritten and the counter reloads HOLD_CYC-1.
- cfg_en deasserted during HOLD: HOLD completes, then goes to OFF.
- rx_en is a registered output. rx_div changes only while rx_en=0.
- Push condition: rx_valid & rx_en. rx_valid while rx_en=0 is dropped silently and does not count as overflow.
- Pop condition: deq_valid & deq_ready.
- deq_bits is the head entry, combinational from FIFO storage. Push-to-deq_valid latency is 1 cycle.
- FIFO pointers are AW bits and wrap modulo DEPTH. fifo_count is a separate AW+1-bit counter.
- Simultaneous push and pop:
  - Not empty: both succeed, count unchanged.
  - Empty: push only; the pop is ignored because deq_valid=0.
  - Full: both succeed; this is not an overflow.
- Full with push and no pop: byte discarded, count stays DEPTH, ovf_flag <= 1.
- ovf_flag is cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- fifo_flush: pointers and count go to 0 next cycle. Any same-cycle push and pop are discarded. ovf_flag is unaffected.
- ip_rxwm = (fifo_count > cfg_rxcnt), combinational.
- cfg_en=0 does not flush the FIFO; buffered bytes remain poppable.

Test Plan:
- Reset, cfg_en=1 -> rx_en rises 1 cycle later. rx_valid with bytes 0x55, 0xA3 -> fifo_count=2, deq_bits=0x55; pop twice returns 0x55 then 0xA3, deq_valid goes 0.
- 9 pushes with no pops, DEPTH=8 -> count stays 8, ovf_flag=1, 9th byte absent. Then ovf_clr and rx_valid in the same cycle while full -> ovf_flag stays 1.
- Full FIFO, push 0x11 and pop in the same cycle -> head advances, 0x11 is the last entry, count stays 8, ovf_flag stays 0.
- In RUN, cfg_div_wr with 0x0100 -> rx_en low for exactly 4 cycles and rx_div=0x0100 before rx_en re-rises. rx_valid during the hold -> no push.
- Second cfg_div_wr with 0x0200 two cycles into HOLD -> hold restarts for 4 cycles, final rx_div=0x0200, 0x0100 never appears.
- cfg_rxcnt=2 with pushes 1, 2, 3 -> ip_rxwm asserts only at count 3. fifo_flush -> count 0 and ip_rxwm 0 next cycle. Async rst_n low mid-HOLD -> rx_div=RST_DIV and state OFF immediately.
